// File: rtl/bip_core_param.sv
// Width-generic accumulator core: FETCH/EXEC/MEM/HALT sequencer with a saturating retire counter.
// Latency: immediate/NOP/branch 2 cycles, memory op 3 cycles plus data-memory wait cycles.
// Backpressure: stalls in MEM with the request held until Ack_DM; optional branches under BIP_BRANCH_EN.
module bip_core_param #(
    parameter int DW    = 16,
    parameter int OPC_W = 5,
    parameter int IM_AW = 11,
    parameter int DM_AW = 11,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             Clear,
    output logic [IM_AW-1:0] Addr,
    input  logic [DW-1:0]    Data,
    output logic [DM_AW-1:0] Addr_DM,
    output logic [DW-1:0]    In_Data,
    input  logic [DW-1:0]    Out_Data,
    output logic             WrRam,
    output logic             RdRam,
    input  logic             Ack_DM,
    output logic             Halted,
    output logic [DW-1:0]    Acc,
    output logic [CNT_W-1:0] Retired
);

    localparam logic [OPC_W-1:0] OP_HLT  = OPC_W'(5'b00000);
    localparam logic [OPC_W-1:0] OP_STO  = OPC_W'(5'b00001);
    localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(5'b00010);
    localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(5'b00011);
    localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(5'b00100);
    localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(5'b00101);
    localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(5'b00110);
    localparam logic [OPC_W-1:0] OP_SUBI = OPC_W'(5'b00111);
`ifdef BIP_BRANCH_EN
    localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(5'b01000);
    localparam logic [OPC_W-1:0] OP_BNE  = OPC_W'(5'b01001);
    localparam logic [OPC_W-1:0] OP_JMP  = OPC_W'(5'b01010);
`endif

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

    state_t           state;
    logic [IM_AW-1:0] pc;
    logic [DW-1:0]    ir;
    logic [DW-1:0]    acc;
    logic [CNT_W-1:0] retired;

    logic [OPC_W-1:0] opc;
    logic [DW-1:0]    imm;
    logic [DM_AW-1:0] dm_addr;
    logic [IM_AW-1:0] pc_inc;
    logic [CNT_W-1:0] retired_inc;

    assign opc         = ir[OPC_W-1:0];
    assign imm         = {{OPC_W{ir[DW-1]}}, ir[DW-1:OPC_W]};
    assign dm_addr     = ir[OPC_W +: DM_AW];
    assign pc_inc      = pc + IM_AW'(1);
    assign retired_inc = (retired == {CNT_W{1'b1}}) ? retired : retired + CNT_W'(1);

`ifdef BIP_BRANCH_EN
    logic             acc_zero;
    logic [IM_AW-1:0] target;
    assign acc_zero = (acc == '0);
    assign target   = ir[OPC_W +: IM_AW];
`endif

    always_ff @(posedge clk) begin
        if (Clear) begin
            state   <= S_FETCH;
            pc      <= '0;
            ir      <= '0;
            acc     <= '0;
            retired <= '0;
            Addr_DM <= '0;
            WrRam   <= 1'b0;
            RdRam   <= 1'b0;
            Halted  <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    ir    <= Data;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    case (opc)
                        OP_HLT: begin
                            state   <= S_HALT;
                            Halted  <= 1'b1;
                            retired <= retired_inc;
                        end
                        OP_LDI, OP_ADDI, OP_SUBI: begin
                            if (opc == OP_LDI)       acc <= imm;
                            else if (opc == OP_ADDI) acc <= acc + imm;
                            else                     acc <= acc - imm;
                            pc      <= pc_inc;
                            retired <= retired_inc;
                            state   <= S_FETCH;
                        end
                        OP_STO: begin
                            Addr_DM <= dm_addr;
                            WrRam   <= 1'b1;
                            state   <= S_MEM;
                        end
                        OP_LD, OP_ADD, OP_SUB: begin
                            Addr_DM <= dm_addr;
                            RdRam   <= 1'b1;
                            state   <= S_MEM;
                        end
`ifdef BIP_BRANCH_EN
                        OP_BEQ, OP_BNE, OP_JMP: begin
                            if ((opc == OP_JMP) ||
                                (opc == OP_BEQ && acc_zero) ||
                                (opc == OP_BNE && !acc_zero))
                                pc <= target;
                            else
                                pc <= pc_inc;
                            retired <= retired_inc;
                            state   <= S_FETCH;
                        end
`endif
                        default: begin
                            pc      <= pc_inc;
                            retired <= retired_inc;
                            state   <= S_FETCH;
                        end
                    endcase
                end
                S_MEM: begin
                    // Request, address and write data stay put until the RAM acknowledges.
                    if (Ack_DM) begin
                        case (opc)
                            OP_LD:   acc <= Out_Data;
                            OP_ADD:  acc <= acc + Out_Data;
                            OP_SUB:  acc <= acc - Out_Data;
                            default: acc <= acc;
                        endcase
                        WrRam   <= 1'b0;
                        RdRam   <= 1'b0;
                        pc      <= pc_inc;
                        retired <= retired_inc;
                        state   <= S_FETCH;
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: state <= S_FETCH;
            endcase
        end
    end

    assign Addr    = pc;
    assign In_Data = acc;
    assign Acc     = acc;
    assign Retired = retired;

endmodule

// File: tb/tb_bip_core_param.sv
module tb_bip_core_param;
    localparam int DW    = 16;
    localparam int IM_AW = 11;
    localparam int DM_AW = 11;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             Clear = 1'b1;
    logic [IM_AW-1:0] Addr;
    logic [DW-1:0]    Data;
    logic [DM_AW-1:0] Addr_DM;
    logic [DW-1:0]    In_Data;
    logic [DW-1:0]    Out_Data;
    logic             WrRam, RdRam, Ack_DM, Halted;
    logic [DW-1:0]    Acc;
    logic [CNT_W-1:0] Retired;

    logic [DW-1:0] imem [0:(1<<IM_AW)-1];
    logic [DW-1:0] dmem [0:(1<<DM_AW)-1];

    typedef struct packed {
        logic             wr;
        logic [DM_AW-1:0] addr;
        logic [DW-1:0]    dat;
    } access_t;

    access_t exp_q[$];
    int      errors = 0;
    int      checks = 0;
    int      ack_delay = 0;
    logic    auto_ack = 1'b1;
    logic    manual_ack = 1'b0;

    always #5 clk = ~clk;

    assign Data = imem[Addr];

    bip_core_param #(.DW(DW), .OPC_W(5), .IM_AW(IM_AW), .DM_AW(DM_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .Clear(Clear), .Addr(Addr), .Data(Data), .Addr_DM(Addr_DM),
        .In_Data(In_Data), .Out_Data(Out_Data), .WrRam(WrRam), .RdRam(RdRam),
        .Ack_DM(Ack_DM), .Halted(Halted), .Acc(Acc), .Retired(Retired)
    );

    // RAM responder: acknowledges each request after ack_delay wait cycles and checks it against the scoreboard.
    initial begin : responder
        int      wait_cnt;
        access_t e;
        wait_cnt = 0;
        Ack_DM   = 1'b0;
        Out_Data = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!auto_ack) begin
                Ack_DM   = manual_ack;
                Out_Data = dmem[Addr_DM];
                wait_cnt = 0;
            end else if (Ack_DM) begin
                Ack_DM   = 1'b0;
                wait_cnt = 0;
            end else if ((RdRam || WrRam) && !Clear) begin
                if (wait_cnt >= ack_delay) begin
                    Ack_DM   = 1'b1;
                    Out_Data = dmem[Addr_DM];
                    if (WrRam) dmem[Addr_DM] = In_Data;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected got wr=%0b addr=%h data=%h, expected no access", WrRam, Addr_DM, In_Data);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.wr !== WrRam || e.addr !== Addr_DM || (e.wr && e.dat !== In_Data)) begin
                            errors++;
                            $display("FAIL sb_access got wr=%0b addr=%h data=%h, expected wr=%0b addr=%h data=%h",
                                     WrRam, Addr_DM, In_Data, e.wr, e.addr, e.dat);
                        end
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        Clear = 1'b1;
        tick();
        tick();
        Clear = 1'b0;
    endtask

    task automatic fill_imem(input logic [DW-1:0] w);
        for (int i = 0; i < (1<<IM_AW); i++) imem[i] = w;
    endtask

    task automatic wait_halt(input int budget);
        int n;
        n = 0;
        while (!Halted && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (Halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_timeout got Halted=%b after %0d cycles, expected 1", Halted, n);
        end
    endtask

    task automatic test_reset();
        fill_imem(16'h001F);
        Clear = 1'b1;
        tick();
        tick();
        checks += 6;
        if (Addr !== '0)    begin errors++; $display("FAIL reset_addr got %h expected 0", Addr); end
        if (Acc !== '0)     begin errors++; $display("FAIL reset_acc got %h expected 0", Acc); end
        if (Retired !== '0) begin errors++; $display("FAIL reset_retired got %h expected 0", Retired); end
        if (Halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b expected 0", Halted); end
        if (WrRam !== 1'b0) begin errors++; $display("FAIL reset_wrram got %b expected 0", WrRam); end
        if (RdRam !== 1'b0) begin errors++; $display("FAIL reset_rdram got %b expected 0", RdRam); end
    endtask

    task automatic test_immediate();
        fill_imem(16'h0000);
        imem[0] = 16'h00A3;   // LDI 5
        imem[1] = 16'hFFC5;   // ADDI -2
        do_reset();
        tick(); tick();
        checks++;
        if (Acc !== 16'd5) begin errors++; $display("FAIL imm_ldi got %h expected 0005", Acc); end
        tick(); tick();
        checks++;
        if (Acc !== 16'd3) begin errors++; $display("FAIL imm_addi got %h expected 0003", Acc); end
        tick();
        checks++;
        if (Halted !== 1'b0) begin errors++; $display("FAIL imm_halt_early got %b expected 0", Halted); end
        tick();
        checks += 3;
        if (Halted !== 1'b1)    begin errors++; $display("FAIL imm_halted got %b expected 1", Halted); end
        if (Retired !== 4'd3)   begin errors++; $display("FAIL imm_retired got %0d expected 3", Retired); end
        if (Addr !== 11'd2)     begin errors++; $display("FAIL imm_addr got %h expected 002", Addr); end
        repeat (3) tick();
        checks += 3;
        if (Addr !== 11'd2)   begin errors++; $display("FAIL halt_addr_frozen got %h expected 002", Addr); end
        if (Acc !== 16'd3)    begin errors++; $display("FAIL halt_acc_frozen got %h expected 0003", Acc); end
        if (Retired !== 4'd3) begin errors++; $display("FAIL halt_ret_frozen got %0d expected 3", Retired); end
    endtask

    task automatic test_store_wait();
        int wr_cycles, rd_cycles, unstable, ret_first, ret_after;
        fill_imem(16'h0000);
        imem[0] = 16'h2463;   // LDI 0x123
        imem[1] = 16'h0201;   // STO 0x010
        ack_delay = 4;
        exp_q.push_back('{wr: 1'b1, addr: 11'h010, dat: 16'h0123});
        wr_cycles = 0; rd_cycles = 0; unstable = 0; ret_first = -1; ret_after = -1;
        do_reset();
        for (int n = 0; n < 40 && !Halted; n++) begin
            tick();
            if (RdRam) rd_cycles++;
            if (WrRam) begin
                if (wr_cycles == 0) ret_first = int'(Retired);
                if (Addr_DM !== 11'h010 || In_Data !== 16'h0123) unstable++;
                wr_cycles++;
            end else if (wr_cycles > 0 && ret_after < 0) begin
                ret_after = int'(Retired);
            end
        end
        checks += 7;
        if (wr_cycles != 5) begin errors++; $display("FAIL sto_wr_cycles got %0d expected 5", wr_cycles); end
        if (rd_cycles != 0) begin errors++; $display("FAIL sto_rd_cycles got %0d expected 0", rd_cycles); end
        if (unstable != 0)  begin errors++; $display("FAIL sto_stable got %0d unstable cycles expected 0", unstable); end
        if (ret_first != 1) begin errors++; $display("FAIL sto_ret_before got %0d expected 1", ret_first); end
        if (ret_after != 2) begin errors++; $display("FAIL sto_ret_after got %0d expected 2", ret_after); end
        if (Halted !== 1'b1 || Retired !== 4'd3) begin
            errors++; $display("FAIL sto_final got halted=%b retired=%0d expected 1/3", Halted, Retired);
        end
        if (dmem[11'h010] !== 16'h0123) begin errors++; $display("FAIL sto_ram got %h expected 0123", dmem[11'h010]); end
        ack_delay = 0;
    endtask

    task automatic test_load_add_wrap();
        fill_imem(16'h0000);
        imem[0] = 16'hFFE2;   // LD 0x7FF
        imem[1] = 16'hFFE4;   // ADD 0x7FF
        dmem[11'h7FF] = 16'hFFFF;
        ack_delay = 0;
        exp_q.push_back('{wr: 1'b0, addr: 11'h7FF, dat: 16'h0000});
        exp_q.push_back('{wr: 1'b0, addr: 11'h7FF, dat: 16'h0000});
        do_reset();
        tick(); tick();
        checks += 2;
        if (RdRam !== 1'b1)   begin errors++; $display("FAIL ld_rdram got %b expected 1", RdRam); end
        if (Retired !== 4'd0) begin errors++; $display("FAIL ld_ret_early got %0d expected 0", Retired); end
        tick();
        checks += 3;
        if (Retired !== 4'd1)    begin errors++; $display("FAIL ld_ret got %0d expected 1", Retired); end
        if (Acc !== 16'hFFFF)    begin errors++; $display("FAIL ld_acc got %h expected ffff", Acc); end
        if (RdRam !== 1'b0)      begin errors++; $display("FAIL ld_rd_drop got %b expected 0", RdRam); end
        dmem[11'h7FF] = 16'h0002;
        tick(); tick(); tick();
        checks += 2;
        if (Retired !== 4'd2) begin errors++; $display("FAIL add_ret got %0d expected 2", Retired); end
        if (Acc !== 16'h0001) begin errors++; $display("FAIL add_wrap got %h expected 0001", Acc); end
    endtask

    task automatic test_clear_mid_mem();
        fill_imem(16'h0000);
        imem[0] = 16'h00A2;   // LD 0x005
        dmem[5] = 16'h1234;
        auto_ack = 1'b0;
        manual_ack = 1'b0;
        do_reset();
        tick(); tick();
        checks++;
        if (RdRam !== 1'b1) begin errors++; $display("FAIL clr_in_mem got RdRam=%b expected 1", RdRam); end
        Clear = 1'b1;
        manual_ack = 1'b1;
        tick();
        checks += 4;
        if (Acc !== '0)       begin errors++; $display("FAIL clr_acc got %h expected 0", Acc); end
        if (RdRam !== 1'b0)   begin errors++; $display("FAIL clr_rdram got %b expected 0", RdRam); end
        if (Addr !== '0)      begin errors++; $display("FAIL clr_pc got %h expected 0", Addr); end
        if (Retired !== '0)   begin errors++; $display("FAIL clr_retired got %0d expected 0", Retired); end
        manual_ack = 1'b0;
        Clear = 1'b0;
        Clear = 1'b1;
        tick();
        auto_ack = 1'b1;
    endtask

    task automatic test_branch();
        logic [DW-1:0] w0 [4];
        logic [DW-1:0] w1 [4];
        int            exp_pc [4];
        w0[0] = 16'h0003; w1[0] = 16'h00A8;   // LDI 0; BEQ 5
        w0[1] = 16'h0023; w1[1] = 16'h00A8;   // LDI 1; BEQ 5
        w0[2] = 16'h0023; w1[2] = 16'h00C9;   // LDI 1; BNE 6
        w0[3] = 16'h0003; w1[3] = 16'h00EA;   // LDI 0; JMP 7
`ifdef BIP_BRANCH_EN
        exp_pc[0] = 5; exp_pc[1] = 2; exp_pc[2] = 6; exp_pc[3] = 7;
`else
        exp_pc[0] = 2; exp_pc[1] = 2; exp_pc[2] = 2; exp_pc[3] = 2;
`endif
        for (int k = 0; k < 4; k++) begin
            fill_imem(16'h0000);
            imem[0] = w0[k];
            imem[1] = w1[k];
            do_reset();
            repeat (4) tick();
            checks += 2;
            if (Addr !== IM_AW'(exp_pc[k])) begin
                errors++; $display("FAIL branch_pc case %0d got %h expected %h", k, Addr, exp_pc[k]);
            end
            if (Retired !== 4'd2) begin
                errors++; $display("FAIL branch_ret case %0d got %0d expected 2", k, Retired);
            end
        end
    endtask

    task automatic test_wrap_saturate();
        int n;
        fill_imem(16'h001F);   // all NOP
        do_reset();
        repeat (28) tick();
        checks++;
        if (Retired !== 4'd14) begin errors++; $display("FAIL sat_pre got %0d expected 14", Retired); end
        repeat (2) tick();
        checks++;
        if (Retired !== 4'd15) begin errors++; $display("FAIL sat_max got %0d expected 15", Retired); end
        repeat (4) tick();
        checks++;
        if (Retired !== 4'd15) begin errors++; $display("FAIL sat_hold got %0d expected 15", Retired); end
        n = 0;
        while (Addr !== 11'h7FF && n < 5000) begin
            tick();
            n++;
        end
        checks++;
        if (Addr !== 11'h7FF) begin errors++; $display("FAIL pc_reach got %h expected 7ff", Addr); end
        tick(); tick();
        checks += 2;
        if (Addr !== 11'h000)  begin errors++; $display("FAIL pc_wrap got %h expected 000", Addr); end
        if (Retired !== 4'd15) begin errors++; $display("FAIL sat_end got %0d expected 15", Retired); end
    endtask

    task automatic test_back_to_back();
        fill_imem(16'h0000);
        imem[0] = 16'hFFE3;   // LDI -1
        imem[1] = 16'h0401;   // STO 0x020
        imem[2] = 16'h0027;   // SUBI 1
        imem[3] = 16'h0402;   // LD 0x020
        imem[4] = 16'h0406;   // SUB 0x020
        dmem[11'h020] = 16'h0000;
        ack_delay = 1;
        exp_q.push_back('{wr: 1'b1, addr: 11'h020, dat: 16'hFFFF});
        exp_q.push_back('{wr: 1'b0, addr: 11'h020, dat: 16'h0000});
        exp_q.push_back('{wr: 1'b0, addr: 11'h020, dat: 16'h0000});
        do_reset();
        wait_halt(80);
        checks += 4;
        if (Acc !== 16'h0000)  begin errors++; $display("FAIL b2b_acc got %h expected 0000", Acc); end
        if (Retired !== 4'd6)  begin errors++; $display("FAIL b2b_ret got %0d expected 6", Retired); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_sb_left got %0d expected 0", exp_q.size()); end
        if (dmem[11'h020] !== 16'hFFFF) begin errors++; $display("FAIL b2b_ram got %h expected ffff", dmem[11'h020]); end
        ack_delay = 0;
    endtask

    initial begin
        for (int i = 0; i < (1<<DM_AW); i++) dmem[i] = '0;
        test_reset();
        test_immediate();
        test_store_wait();
        test_load_add_wrap();
        test_clear_mid_mem();
        test_branch();
        test_wrap_saturate();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d expected 0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
